// File: rtl/if_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack channel, redirect input and the
// valid/ready channel towards decode.
interface if_fetch_if #(
  parameter int PC_WIDTH    = 6,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   id_ready;
  logic                   id_valid;
  logic [INSTR_WIDTH-1:0] Instruction;
  logic [PC_WIDTH-1:0]    PCnext;

  modport master (
    output imem_req, imem_addr, id_valid, Instruction, PCnext,
    input  imem_ack, imem_data, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, Instruction, PCnext,
    output imem_ack, imem_data, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues single-outstanding memory requests,
// buffers returned words and hands {Instruction, PCnext} to decode.
module if_fetch #(
  parameter int PC_WIDTH    = 6,
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH  = 2,
  parameter int RESET_PC    = 0
) (
  input logic        clk,
  input logic        rst,
  if_fetch_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = INSTR_WIDTH + PC_WIDTH;
  localparam logic [CNT_W-1:0]    DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [PC_WIDTH-1:0] RESET_PC_C = PC_WIDTH'(RESET_PC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DISCARD
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] stale_q, stale_d;
  logic [PTR_W-1:0]    wr_q, wr_d;
  logic [PTR_W-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];

  logic                push;
  logic                pop;
  logic                flush;
  logic [CNT_W-1:0]    cnt_pop;
  logic                valid;
  logic [ENT_W-1:0]    head;

  assign valid   = (cnt_q != '0);
  assign pop     = valid && bus.id_ready;
  assign cnt_pop = cnt_q - CNT_W'(pop);

  // Redirect takes priority over any returning data; a same-cycle pop still
  // completes because it is counted before the flush clears the buffer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.redirect) begin
          flush   = 1'b1;
          pc_d    = bus.redirect_pc;
          state_d = S_REQ;
        end else if (cnt_pop < DEPTH_C) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.redirect) begin
          flush = 1'b1;
          pc_d  = bus.redirect_pc;
          if (bus.imem_ack) begin
            state_d = S_REQ;
          end else begin
            stale_d = pc_q;
            state_d = S_DISCARD;
          end
        end else if (bus.imem_ack) begin
          push    = 1'b1;
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = ((cnt_pop + CNT_W'(1)) < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        if (bus.redirect) begin
          flush = 1'b1;
          pc_d  = bus.redirect_pc;
        end
        if (bus.imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + PTR_W'(push);
      rd_d  = rd_q + PTR_W'(pop);
      cnt_d = cnt_pop + CNT_W'(push);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC_C;
      stale_q <= RESET_PC_C;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry storage needs no reset: it is only visible while the count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= {bus.imem_data, pc_q + PC_WIDTH'(1)};
    end
  end

  assign head = mem_q[rd_q];

  assign bus.imem_req    = (state_q != S_IDLE);
  assign bus.imem_addr   = (state_q == S_DISCARD) ? stale_q : pc_q;
  assign bus.id_valid    = valid;
  assign bus.Instruction = valid ? head[ENT_W-1:PC_WIDTH] : '0;
  assign bus.PCnext      = valid ? head[PC_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a cycle table for start-up and back-pressure, then a
// scoreboard of expected decode transfers for the redirect/wrap/reset cases.
module tb_if_fetch;
  logic clk;
  logic rst;

  if_fetch_if #(.PC_WIDTH(6), .INSTR_WIDTH(32)) bus ();

  if_fetch #(
    .PC_WIDTH   (6),
    .INSTR_WIDTH(32),
    .FIFO_DEPTH (2),
    .RESET_PC   (0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       rdy;
    logic       req;
    logic [5:0] addr;
    logic       vld;
    logic [5:0] pcn;
  } row_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [5:0]  pcn;
  } exp_t;

  row_t        tbl [9];
  exp_t        exp_q [$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          first_cyc;
  int          last_cyc;
  int          n;
  bit          mon_en;
  bit          mem_auto;
  int          lat;
  int          wcnt = 0;
  logic        auto_ack = 1'b0;
  logic        man_ack;
  logic [31:0] man_data;

  function automatic logic [31:0] memdata(logic [5:0] a);
    return {16'hC0DE, 4'h0, a, a};
  endfunction

  // Memory model: acks a held request after lat wait cycles.
  assign bus.imem_ack  = mem_auto ? auto_ack : man_ack;
  assign bus.imem_data = mem_auto ? memdata(bus.imem_addr) : man_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus.imem_req) begin
      if (wcnt >= lat) begin
        auto_ack <= 1'b1;
        wcnt     <= 0;
      end else begin
        auto_ack <= 1'b0;
        wcnt     <= wcnt + 1;
      end
    end else begin
      auto_ack <= 1'b0;
      wcnt     <= 0;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push_exp(logic [5:0] a);
    exp_q.push_back({memdata(a), a + 6'd1});
  endtask

  // One cycle: observe a decode transfer at the falling edge, then advance.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (mon_en && bus.id_valid && bus.id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_xfer: got PCnext=%0h Instruction=%0h, expected no transfer",
                 bus.PCnext, bus.Instruction);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_instr", 64'(bus.Instruction), 64'(e.ins));
        chk("xfer_pcnext", 64'(bus.PCnext), 64'(e.pcn));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic drain(int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    bus.id_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    bus.redirect = 1'b0;
    bus.id_ready = 1'b0;
    man_ack      = 1'b0;
    exp_q.delete();
    first_cyc = -1;
    last_cyc  = -1;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 6'd0, 1'b0, 6'd0};
    tbl[1] = '{1'b1, 1'b1, 6'd0, 1'b0, 6'd0};
    tbl[2] = '{1'b1, 1'b1, 6'd1, 1'b1, 6'd1};
    tbl[3] = '{1'b0, 1'b1, 6'd2, 1'b1, 6'd2};
    tbl[4] = '{1'b0, 1'b0, 6'd3, 1'b1, 6'd2};
    tbl[5] = '{1'b0, 1'b0, 6'd3, 1'b1, 6'd2};
    tbl[6] = '{1'b1, 1'b0, 6'd3, 1'b1, 6'd2};
    tbl[7] = '{1'b1, 1'b1, 6'd3, 1'b1, 6'd3};
    tbl[8] = '{1'b1, 1'b1, 6'd4, 1'b1, 6'd4};

    rst             = 1'b1;
    bus.id_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    man_ack         = 1'b0;
    man_data        = '0;
    mem_auto        = 1'b0;
    lat             = 0;
    mon_en          = 1'b0;
    first_cyc       = -1;
    last_cyc        = -1;
    #1 rst = 1'b0;
    @(posedge clk);
    #2;

    // Reset held with toggling inputs
    for (int i = 0; i < 6; i++) begin
      man_ack         = 1'($urandom_range(0, 1));
      man_data        = $urandom;
      bus.redirect    = 1'($urandom_range(0, 1));
      bus.redirect_pc = 6'($urandom);
      bus.id_ready    = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_req", 64'(bus.imem_req), 64'd0);
      chk("rst_valid", 64'(bus.id_valid), 64'd0);
      chk("rst_instr", 64'(bus.Instruction), 64'd0);
      chk("rst_pcnext", 64'(bus.PCnext), 64'd0);
      @(posedge clk);
      #2;
    end

    // Start-up, streaming and back-pressure, cycle by cycle
    man_ack      = 1'b0;
    bus.redirect = 1'b0;
    mem_auto     = 1'b1;
    lat          = 0;
    rst          = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.id_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i), 64'(bus.imem_req), 64'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), 64'(bus.imem_addr), 64'(tbl[i].addr));
      chk($sformatf("tbl%0d_valid", i), 64'(bus.id_valid), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d_pcnext", i), 64'(bus.PCnext), 64'(tbl[i].pcn));
      chk($sformatf("tbl%0d_instr", i), 64'(bus.Instruction),
          tbl[i].vld ? 64'(memdata(tbl[i].pcn - 6'd1)) : 64'd0);
      @(posedge clk);
      #2;
    end
    mon_en = 1'b1;

    // Zero-wait stream: one word per cycle
    do_reset();
    lat          = 0;
    bus.id_ready = 1'b1;
    for (int a = 0; a < 10; a++) push_exp(6'(a));
    drain(40);
    chk("stream_span", 64'(last_cyc - first_cyc), 64'd9);

    // Back-pressure: buffer fills with two words and requests stop
    do_reset();
    lat = 0;
    repeat (10) step();
    chk("bp_req", 64'(bus.imem_req), 64'd0);
    chk("bp_valid", 64'(bus.id_valid), 64'd1);
    chk("bp_head", 64'(bus.PCnext), 64'd1);
    for (int a = 0; a < 5; a++) push_exp(6'(a));
    bus.id_ready = 1'b1;
    step();
    chk("bp_req_rise", 64'(bus.imem_req), 64'd1);
    drain(40);

    // Redirect while the request to 5 waits on a 3-cycle memory
    do_reset();
    lat          = 3;
    bus.id_ready = 1'b1;
    for (int a = 0; a < 5; a++) push_exp(6'(a));
    drain(80);
    n = 0;
    while (!(bus.imem_req && bus.imem_addr == 6'd5 && !bus.imem_ack) && n < 20) begin
      step();
      n++;
    end
    chk("rd_pending_addr", 64'(bus.imem_addr), 64'd5);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 6'h20;
    step();
    bus.redirect = 1'b0;
    chk("rd_valid_drop", 64'(bus.id_valid), 64'd0);
    chk("rd_stale_req", 64'(bus.imem_req), 64'd1);
    chk("rd_stale_addr", 64'(bus.imem_addr), 64'd5);
    n = 0;
    while (!bus.imem_ack && n < 10) begin
      step();
      n++;
    end
    step();
    chk("rd_new_req", 64'(bus.imem_req), 64'd1);
    chk("rd_new_addr", 64'(bus.imem_addr), 64'h20);
    push_exp(6'h20);
    bus.id_ready = 1'b1;
    drain(20);

    // Redirect in the same cycle as the ack of address 7
    do_reset();
    lat          = 2;
    bus.id_ready = 1'b1;
    for (int a = 0; a < 7; a++) push_exp(6'(a));
    drain(80);
    n = 0;
    while (!(bus.imem_req && bus.imem_addr == 6'd7 && bus.imem_ack) && n < 20) begin
      step();
      n++;
    end
    chk("ra_ack7", 64'({bus.imem_ack, bus.imem_addr}), 64'({1'b1, 6'd7}));
    bus.redirect    = 1'b1;
    bus.redirect_pc = 6'h30;
    step();
    bus.redirect = 1'b0;
    chk("ra_valid_drop", 64'(bus.id_valid), 64'd0);
    chk("ra_new_addr", 64'(bus.imem_addr), 64'h30);
    push_exp(6'h30);
    bus.id_ready = 1'b1;
    drain(20);

    // PC wrap at the top of the address space
    do_reset();
    lat             = 0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 6'd62;
    step();
    bus.redirect = 1'b0;
    chk("wrap_addr", 64'(bus.imem_addr), 64'd62);
    push_exp(6'd62);
    push_exp(6'd63);
    push_exp(6'd0);
    bus.id_ready = 1'b1;
    drain(20);

    // Reset asserted while discarding a stale request
    do_reset();
    mem_auto = 1'b0;
    lat      = 0;
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 6'h10;
    step();
    bus.redirect = 1'b0;
    chk("rdis_req", 64'(bus.imem_req), 64'd1);
    chk("rdis_stale_addr", 64'(bus.imem_addr), 64'd0);
    #1 rst = 1'b0;
    #1;
    chk("rdis_rst_req", 64'(bus.imem_req), 64'd0);
    chk("rdis_rst_valid", 64'(bus.id_valid), 64'd0);
    chk("rdis_rst_instr", 64'(bus.Instruction), 64'd0);
    chk("rdis_rst_pcnext", 64'(bus.PCnext), 64'd0);
    man_ack  = 1'b1;
    man_data = 32'hDEAD_BEEF;
    step();
    step();
    rst = 1'b1;
    step();
    man_ack  = 1'b0;
    mem_auto = 1'b1;
    chk("rdis_restart_req", 64'(bus.imem_req), 64'd1);
    chk("rdis_restart_addr", 64'(bus.imem_addr), 64'd0);
    chk("rdis_restart_valid", 64'(bus.id_valid), 64'd0);
    push_exp(6'd0);
    bus.id_ready = 1'b1;
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
